// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control codes, ALUOp/funct encodings
// and the issuer state type. Imported by the issuer and the ALU.
package alu_defs_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_FN  = 3'b010;
  localparam logic [2:0] ALUOP_SLT = 3'b011;
  localparam logic [2:0] ALUOP_OR  = 3'b100;
  localparam logic [2:0] ALUOP_AND = 3'b101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ONE,
    S_MULH
  } state_e;

endpackage

// File: rtl/alu_ctrl_issuer_if.sv
// Request/response bundle between ID/EX, the issuer and the ALU.
// The master side is the requester; the issuer is the slave.
interface alu_ctrl_issuer_if;
  logic       valid_i;
  logic       ready_o;
  logic [2:0] aluop_i;
  logic [5:0] funct_i;
  logic       flush_i;
  logic [3:0] ctrl_o;
  logic       ctrl_valid_o;
  logic       ctrl_last_o;
  logic       illegal_o;

  modport master (
    output valid_i, aluop_i, funct_i, flush_i,
    input  ready_o, ctrl_o, ctrl_valid_o,
    input  ctrl_last_o, illegal_o
  );

  modport slave (
    input  valid_i, aluop_i, funct_i, flush_i,
    output ready_o, ctrl_o, ctrl_valid_o,
    output ctrl_last_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUOp, funct} to ALU control code decode.
// Flags multiplies and requests with no legal operation.
import alu_defs_pkg::*;

module alu_ctrl_decode (
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       is_mul,
  output logic       illegal
);

  logic [3:0] fn_code;
  logic       fn_ill;

  always_comb begin
    fn_code = ALU_ILL;
    fn_ill  = 1'b0;
    case (funct)
      FN_ADD:  fn_code = ALU_ADD;
      FN_SUB:  fn_code = ALU_SUB;
      FN_AND:  fn_code = ALU_AND;
      FN_OR:   fn_code = ALU_OR;
      FN_NOR:  fn_code = ALU_NOR;
      FN_SLT:  fn_code = ALU_SLT;
      FN_MUL:  fn_code = ALU_MUL;
      default: fn_ill  = 1'b1;
    endcase
  end

  always_comb begin
    code    = ALU_ILL;
    illegal = 1'b0;
    unique case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_SLT: code = ALU_SLT;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_AND: code = ALU_AND;
      ALUOP_FN: begin
        code    = fn_code;
        illegal = fn_ill;
      end
      default:   illegal = 1'b1;
    endcase
  end

  assign is_mul = !illegal && (code == ALU_MUL);

endmodule

// File: rtl/alu_ctrl_issuer.sv
// Issues registered ALU control codes; holds multiplies for
// MUL_LAT cycles while back-pressuring the requester.
import alu_defs_pkg::*;

module alu_ctrl_issuer #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_ctrl_issuer_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_INIT =
    CNT_W'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             ill_q, ill_d;

  logic [3:0] dec_code;
  logic       dec_mul;
  logic       dec_ill;
  logic       hold;
  logic       accept;

  alu_ctrl_decode u_dec (
    .aluop   (bus.aluop_i),
    .funct   (bus.funct_i),
    .code    (dec_code),
    .is_mul  (dec_mul),
    .illegal (dec_ill)
  );

  assign hold   = (state_q == S_MULH) && (cnt_q != '0);
  assign bus.ready_o = !rst_i && !hold;
  assign accept = bus.valid_i && bus.ready_o && !bus.flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = 1'b0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (hold) begin
      cnt_d = cnt_q - 1'b1;
    end else if (accept) begin
      unique case (1'b1)
        dec_ill: begin
          state_d = S_IDLE;
          ctrl_d  = ALU_ILL;
          ill_d   = 1'b1;
        end
        dec_mul: begin
          state_d = S_MULH;
          cnt_d   = HOLD_INIT;
          ctrl_d  = ALU_MUL;
        end
        default: begin
          state_d = S_ONE;
          ctrl_d  = dec_code;
        end
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= ALU_AND;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ctrl_o       = ctrl_q;
  assign bus.ctrl_valid_o = (state_q != S_IDLE);
  assign bus.ctrl_last_o  = (state_q == S_ONE) ||
    ((state_q == S_MULH) && (cnt_q == '0));
  assign bus.illegal_o    = ill_q;

endmodule

// File: tb/tb_alu_ctrl_issuer.sv
// Bench for alu_ctrl_issuer: decode table, multiply hold,
// flush and reset corners, plus a MUL_LAT=1 instance.
module tb_alu_ctrl_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_issuer_if bus ();
  alu_ctrl_issuer_if bus1 ();

  alu_ctrl_issuer #(.MUL_LAT(4), .CNT_W(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  alu_ctrl_issuer #(.MUL_LAT(1), .CNT_W(4)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] code;
    logic       vld;
    logic       last;
    logic       ill;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t tbl[14];

  task automatic chk4(string n, logic [3:0] act, logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", n, act, want);
    end
  endtask

  task automatic chk1(string n, logic act, logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", n, act, want);
    end
  endtask

  task automatic push(string n, logic [3:0] c, logic v,
                      logic l, logic i, logic r);
    exp_t e;
    e.name = n; e.code = c; e.vld = v;
    e.last = l; e.ill = i; e.rdy = r;
    sb.push_back(e);
  endtask

  task automatic drive(logic v, logic [2:0] op,
                       logic [5:0] fn, logic fl);
    bus.valid_i = v;
    bus.aluop_i = op;
    bus.funct_i = fn;
    bus.flush_i = fl;
  endtask

  task automatic drive1(logic v, logic [2:0] op, logic [5:0] fn);
    bus1.valid_i = v;
    bus1.aluop_i = op;
    bus1.funct_i = fn;
    bus1.flush_i = 1'b0;
  endtask

  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      chk4({e.name, "_code"}, bus.ctrl_o, e.code);
      chk1({e.name, "_vld"}, bus.ctrl_valid_o, e.vld);
      chk1({e.name, "_last"}, bus.ctrl_last_o, e.last);
      chk1({e.name, "_ill"}, bus.illegal_o, e.ill);
      chk1({e.name, "_rdy"}, bus.ready_o, e.rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
    tbl[1]  = '{3'b001, 6'b000000, 4'b0110, 1'b0};
    tbl[2]  = '{3'b011, 6'b000000, 4'b0111, 1'b0};
    tbl[3]  = '{3'b100, 6'b000000, 4'b0001, 1'b0};
    tbl[4]  = '{3'b101, 6'b000000, 4'b0000, 1'b0};
    tbl[5]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
    tbl[6]  = '{3'b010, 6'b100010, 4'b0110, 1'b0};
    tbl[7]  = '{3'b010, 6'b000111, 4'b1111, 1'b1};
    tbl[8]  = '{3'b010, 6'b100100, 4'b0000, 1'b0};
    tbl[9]  = '{3'b010, 6'b100101, 4'b0001, 1'b0};
    tbl[10] = '{3'b010, 6'b100111, 4'b1100, 1'b0};
    tbl[11] = '{3'b010, 6'b101010, 4'b0111, 1'b0};
    tbl[12] = '{3'b110, 6'b000000, 4'b1111, 1'b1};
    tbl[13] = '{3'b111, 6'b100000, 4'b1111, 1'b1};

    drive(0, 3'b000, 6'b000000, 0);
    drive1(0, 3'b000, 6'b000000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk4("rst_code", bus.ctrl_o, 4'b0000);
    chk1("rst_vld", bus.ctrl_valid_o, 1'b0);
    chk1("rst_last", bus.ctrl_last_o, 1'b0);
    chk1("rst_ill", bus.illegal_o, 1'b0);
    chk1("rst_rdy", bus.ready_o, 1'b0);
    chk1("rst1_vld", bus1.ctrl_valid_o, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(1, tbl[i].op, tbl[i].fn, 0);
      #1;
      chk1($sformatf("tbl%0d_rdy_in", i), bus.ready_o, 1'b1);
      push($sformatf("tbl%0d", i), tbl[i].code,
           !tbl[i].ill, !tbl[i].ill, tbl[i].ill, 1'b1);
      step_check();
    end

    drive(0, 3'b000, 6'b000000, 0);
    push("idle", 4'b1111, 0, 0, 0, 1);
    step_check();

    drive(1, 3'b010, 6'b011000, 0);
    push("mul_h1", 4'b0011, 1, 0, 0, 0);
    step_check();
    drive(1, 3'b001, 6'b000000, 0);
    push("mul_h2", 4'b0011, 1, 0, 0, 0);
    step_check();
    push("mul_h3", 4'b0011, 1, 0, 0, 0);
    step_check();
    push("mul_h4", 4'b0011, 1, 1, 0, 1);
    step_check();
    push("mul_sub", 4'b0110, 1, 1, 0, 1);
    step_check();
    drive(0, 3'b000, 6'b000000, 0);
    push("mul_idle", 4'b0110, 0, 0, 0, 1);
    step_check();

    drive(1, 3'b010, 6'b011000, 0);
    push("fl_h1", 4'b0011, 1, 0, 0, 0);
    step_check();
    drive(0, 3'b000, 6'b000000, 0);
    push("fl_h2", 4'b0011, 1, 0, 0, 0);
    step_check();
    drive(1, 3'b000, 6'b000000, 1);
    push("fl_kill", 4'b0011, 0, 0, 0, 1);
    step_check();
    drive(0, 3'b000, 6'b000000, 0);
    push("fl_noadd", 4'b0011, 0, 0, 0, 1);
    step_check();

    drive(1, 3'b010, 6'b011000, 0);
    push("rm_h1", 4'b0011, 1, 0, 0, 0);
    step_check();
    drive(0, 3'b000, 6'b000000, 0);
    push("rm_h2", 4'b0011, 1, 0, 0, 0);
    step_check();
    rst = 1'b1;
    push("rm_rst", 4'b0000, 0, 0, 0, 0);
    step_check();
    rst = 1'b0;
    push("rm_after", 4'b0000, 0, 0, 0, 1);
    step_check();

    drive1(1, 3'b010, 6'b011000);
    @(posedge clk);
    #1;
    chk4("l1_mul_code", bus1.ctrl_o, 4'b0011);
    chk1("l1_mul_vld", bus1.ctrl_valid_o, 1'b1);
    chk1("l1_mul_last", bus1.ctrl_last_o, 1'b1);
    chk1("l1_mul_rdy", bus1.ready_o, 1'b1);
    drive1(1, 3'b000, 6'b000000);
    @(posedge clk);
    #1;
    chk4("l1_add_code", bus1.ctrl_o, 4'b0010);
    chk1("l1_add_vld", bus1.ctrl_valid_o, 1'b1);
    chk1("l1_add_last", bus1.ctrl_last_o, 1'b1);
    drive1(0, 3'b000, 6'b000000);
    @(posedge clk);
    #1;
    chk1("l1_idle_vld", bus1.ctrl_valid_o, 1'b0);
    chk1("l1_idle_last", bus1.ctrl_last_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_issuer.md
Name: alu_ctrl_issuer

Overview:
- Producer side of the ALU `ctrl_i` interface.
- Accepts decode requests `{ALUOp, funct}` from the ID/EX stage through a valid/ready handshake.
- Registers the 4-bit ALU control code for the ALU to consume.
- Holds the code stable for `MUL_LAT` cycles on multiply, and back-pressures the pipeline until the multiply completes.

Parameters:
- MUL_LAT, 4, number of cycles a multiply control code is held at the ALU (legal range 1..15).
- CNT_W, 4, width of the internal hold counter (must satisfy 2^CNT_W > MUL_LAT).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  request present.
- ready_o  out  1  issuer can accept a request this cycle.
- aluop_i  in  3  main-control ALUOp.
- funct_i  in  6  instruction funct field (used only when ALUOp=010).
- flush_i  in  1  synchronous kill of the in-flight operation.
- ctrl_o  out  4  ALU control code.
- ctrl_valid_o  out  1  `ctrl_o` is meaningful this cycle.
- ctrl_last_o  out  1  final cycle of the current operation.
- illegal_o  out  1  one-cycle pulse: the accepted request decoded to no legal operation.

Behaviour:
- Control code encoding: AND=0000, OR=0001, ADD=0010, MUL=0011, SUB=0110, SLT=0111, NOR=1100.
- ALUOp decode:
  - 000 -> ADD
  - 001 -> SUB
  - 010 -> decode by funct
  - 011 -> SLT
  - 100 -> OR
  - 101 -> AND
  - 110 and 111 -> illegal
- funct decode (when ALUOp=010): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 011000 MUL; any other funct -> illegal.
- States:
  - IDLE: no operation presented.
  - ONE: single-cycle operation presented.
  - MULH: multiply being held.
- Accept condition: `valid_i && ready_o && !flush_i`.
- `ready_o` (combinational):
  - 0 while `rst_i` is high.
  - 0 in MULH while `cnt != 0`.
  - 1 otherwise, including the last MULH cycle, so back-to-back issue is allowed.
- Latency: 1 cycle. The decoded code appears on `ctrl_o` in the cycle after accept.
- Non-MUL legal accept:
  - Next state ONE.
  - `ctrl_valid_o=1` and `ctrl_last_o=1` for exactly 1 cycle.
- MUL accept:
  - Next state MULH, `cnt` loaded with MUL_LAT-1.
  - `ctrl_o` is held at 0011 and `ctrl_valid_o=1` for MUL_LAT cycles.
  - `cnt` decrements each cycle.
  - `ctrl_last_o=1` only when `cnt==0`.
  - With MUL_LAT=1, a multiply behaves exactly like a single-cycle operation.
- Illegal accept:
  - Next state IDLE.
  - `ctrl_o` forced to 1111 (the ALU yields 0).
  - `ctrl_valid_o=0`.
  - `illegal_o=1` for 1 cycle.
- Transitions:
  - From ONE, or from the last MULH cycle: a new accept is decoded as above; with no accept, go to IDLE.
  - In IDLE: `ctrl_valid_o=0`, `ctrl_last_o=0`, `ctrl_o` retains its last value.
- Flush: `flush_i=1` has priority over everything except reset.
  - Next cycle: state IDLE, `ctrl_valid_o=0`, `ctrl_last_o=0`, `cnt=0`.
  - A request offered in the flush cycle is dropped, not accepted.
- Reset:
  - State IDLE, `ctrl_o=0000`, `ctrl_valid_o=0`, `ctrl_last_o=0`, `illegal_o=0`, `cnt=0`.
  - Reset in the middle of a multiply abandons it immediately, with no `ctrl_last_o`.
- `valid_i` while `ready_o=0` is ignored; the requester holds its request.

Decomposition:
- Shared package alu_defs_pkg holds:
  - the ctrl code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT, ALU_NOR, ALU_ILL=1111);
  - the ALUOp and funct constants;
  - a state enum typedef.
- The ALU itself also imports the package.
- One natural sub-module: alu_ctrl_decode, a purely combinational decode of `{aluop, funct}` to `{code, is_mul, illegal}`. The top level holds the FSM, the counter and the output registers.

Test Plan:
- Reset, then valid_i=1, ALUOp=010, funct=100000 -> next cycle ctrl_o=0010, ctrl_valid_o=1, ctrl_last_o=1; following cycle with no request, ctrl_valid_o=0.
- Back-to-back requests ALUOp 000, 001, 011, 100 on consecutive cycles -> ctrl_o = 0010, 0110, 0111, 0001 on consecutive cycles, ready_o=1 throughout.
- MUL_LAT=4, funct=011000 -> ctrl_o=0011 valid for 4 cycles; ready_o=0 for the first 3; ctrl_last_o on the 4th; a SUB request offered in the 4th cycle appears as 0110 on the 5th.
- ALUOp=010 with funct=000111, and separately ALUOp=111 -> illegal_o pulses once, ctrl_o=1111, ctrl_valid_o=0.
- MUL accepted, flush_i at hold cycle 2 together with a valid ADD request -> next cycle ctrl_valid_o=0, state IDLE, ADD not issued, ready_o=1.
- Reset asserted at hold cycle 2 of a MUL -> next cycle all outputs at reset values and no ctrl_last_o; rebuild with MUL_LAT=1 and issue MUL -> behaves exactly like a single-cycle op.
